// File: rtl/mips_cycle_sequencer_if.sv
// Control/status bundle between the top-level buttons/switches, the phase
// sequencer and the MIPS core's count_state input.
interface mips_cycle_sequencer_if #(
  parameter int unsigned PHASE_WIDTH  = 3,
  parameter int unsigned ICOUNT_WIDTH = 16
);
  logic                    enable;
  logic                    run_mode;
  logic                    step;
  logic                    stall;
  logic                    halt_req;
  logic [PHASE_WIDTH-1:0]  last_phase;
  logic [PHASE_WIDTH-1:0]  count_state;
  logic                    phase_valid;
  logic                    instr_done;
  logic                    halted;
  logic [ICOUNT_WIDTH-1:0] instr_count;

  modport master (
    output enable, run_mode, step, stall, halt_req, last_phase,
    input  count_state, phase_valid, instr_done, halted, instr_count
  );

  modport slave (
    input  enable, run_mode, step, stall, halt_req, last_phase,
    output count_state, phase_valid, instr_done, halted, instr_count
  );
endinterface

// File: rtl/mips_cycle_sequencer.sv
// Phase scheduler for the multicycle MIPS core: variable-length instructions,
// stall hold, free-run / single-step and halt at instruction boundaries.
module mips_cycle_sequencer #(
  parameter int unsigned PHASE_WIDTH  = 3,
  parameter int unsigned MAX_PHASE    = 6,
  parameter int unsigned ICOUNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  mips_cycle_sequencer_if.slave io_seq
);
  localparam logic [PHASE_WIDTH-1:0] MAX_P = PHASE_WIDTH'(MAX_PHASE);
  localparam logic [PHASE_WIDTH-1:0] TWO_P = PHASE_WIDTH'(2);

  typedef enum logic {S_HALT, S_RUN} state_t;

  state_t                  r_state, w_state_nx;
  logic [PHASE_WIDTH-1:0]  r_count_state, w_count_nx;
  logic [PHASE_WIDTH-1:0]  r_last_q, w_last_nx;
  logic [ICOUNT_WIDTH-1:0] r_instr_count, w_icount_nx;
  logic                    r_step_q;
  logic                    w_step_pulse;
  logic                    w_phase_valid;
  logic                    w_final;
  logic                    w_instr_done;
  logic [PHASE_WIDTH-1:0]  w_last_clamped;

  assign w_step_pulse  = io_seq.step & ~r_step_q;
  assign w_phase_valid = (r_state == S_RUN) & io_seq.enable & ~io_seq.stall;
  // Reaching MAX_P also ends the instruction so count_state can never overrun.
  assign w_final = (r_count_state >= TWO_P) &&
                   ((r_count_state == r_last_q) || (r_count_state >= MAX_P));

  always_comb begin
    w_last_clamped = io_seq.last_phase;
    if (io_seq.last_phase < TWO_P)
      w_last_clamped = TWO_P;
    else if (io_seq.last_phase > MAX_P)
      w_last_clamped = MAX_P;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count_state;
    w_last_nx    = r_last_q;
    w_icount_nx  = r_instr_count;
    w_instr_done = 1'b0;
    unique case (r_state)
      S_HALT: begin
        w_count_nx = '0;
        if (io_seq.enable &&
            ((io_seq.run_mode && !io_seq.halt_req) || w_step_pulse))
          w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_phase_valid) begin
          if (w_final) begin
            w_instr_done = 1'b1;
            w_count_nx   = '0;
            w_icount_nx  = r_instr_count + ICOUNT_WIDTH'(1);
            w_last_nx    = MAX_P;
            if (!io_seq.run_mode || io_seq.halt_req)
              w_state_nx = S_HALT;
          end else begin
            w_count_nx = r_count_state + PHASE_WIDTH'(1);
            if (r_count_state == PHASE_WIDTH'(1))
              w_last_nx = w_last_clamped;
          end
        end
      end
      default: w_state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_HALT;
      r_count_state <= '0;
      r_last_q      <= MAX_P;
      r_instr_count <= '0;
      r_step_q      <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_count_state <= w_count_nx;
      r_last_q      <= w_last_nx;
      r_instr_count <= w_icount_nx;
      r_step_q      <= io_seq.step;
    end
  end

  assign io_seq.count_state = r_count_state;
  assign io_seq.phase_valid = w_phase_valid;
  assign io_seq.instr_done  = w_instr_done;
  assign io_seq.halted      = (r_state == S_HALT);
  assign io_seq.instr_count = r_instr_count;
endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Directed-vector bench for mips_cycle_sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_mips_cycle_sequencer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mips_cycle_sequencer_if #(.PHASE_WIDTH(3), .ICOUNT_WIDTH(16)) bus ();

  mips_cycle_sequencer #(
    .PHASE_WIDTH (3),
    .MAX_PHASE   (6),
    .ICOUNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_seq(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Checks len-phase instructions back to back, starting at phase 0.
  task automatic run_expect(input int n, input int len, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cs"}, int'(bus.count_state), i % len);
      chk({tag, "_pv"}, int'(bus.phase_valid), 1);
      chk({tag, "_done"}, int'(bus.instr_done), int'((i % len) == (len - 1)));
      chk({tag, "_range"}, int'(bus.count_state <= 3'd6), 1);
      @(negedge clk);
    end
  endtask

  // Applies a step waveform (bit i during cycle i) and returns phase_valid count.
  task automatic step_seq(input logic [23:0] pat, output int pv_cnt);
    logic [23:0] p;
    p = pat;
    pv_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      bus.step = p[i];
      @(negedge clk);
      if (bus.phase_valid) pv_cnt++;
    end
    bus.step = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int pv;
    n_vec = 0;
    n_err = 0;
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.run_mode   = 1'b0;
    bus.step       = 1'b0;
    bus.stall      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.last_phase = 3'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_halted", int'(bus.halted), 1);
    chk("rst_cs", int'(bus.count_state), 0);
    chk("rst_pv", int'(bus.phase_valid), 0);
    chk("rst_done", int'(bus.instr_done), 0);
    chk("rst_icount", int'(bus.instr_count), 0);

    // Free-run, 5-phase instructions
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.run_mode   = 1'b1;
    bus.last_phase = 3'd4;
    @(negedge clk);
    chk("start_halted", int'(bus.halted), 0);
    run_expect(15, 5, "lp4");
    chk("lp4_icount", int'(bus.instr_count), 3);

    // Clamp low: last_phase=0 behaves as 2
    bus.last_phase = 3'd0;
    run_expect(6, 3, "lp0");
    chk("lp0_icount", int'(bus.instr_count), 5);

    // Clamp high: last_phase=7 behaves as 6
    bus.last_phase = 3'd7;
    run_expect(14, 7, "lp7");
    chk("lp7_icount", int'(bus.instr_count), 7);

    // Stall at phase 2 for 5 cycles, then on the final phase for 3 cycles
    bus.last_phase = 3'd4;
    @(negedge clk);
    @(negedge clk);
    chk("stl_pre_cs", int'(bus.count_state), 2);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stl_cs", int'(bus.count_state), 2);
      chk("stl_pv", int'(bus.phase_valid), 0);
    end
    bus.stall = 1'b0;
    #1;
    chk("stl_resume_pv", int'(bus.phase_valid), 1);
    @(negedge clk);
    chk("stl_resume_cs", int'(bus.count_state), 3);
    @(negedge clk);
    chk("stlf_cs", int'(bus.count_state), 4);
    bus.stall = 1'b1;
    #1;
    chk("stlf_done0", int'(bus.instr_done), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stlf_hold_cs", int'(bus.count_state), 4);
      chk("stlf_hold_done", int'(bus.instr_done), 0);
      chk("stlf_hold_icount", int'(bus.instr_count), 7);
    end
    bus.stall = 1'b0;
    #1;
    chk("stlf_done1", int'(bus.instr_done), 1);
    @(negedge clk);
    chk("stlf_next_cs", int'(bus.count_state), 0);
    chk("stlf_icount", int'(bus.instr_count), 8);

    // halt_req raised at phase 1: instruction completes, then HALT
    @(negedge clk);
    chk("hr_cs1", int'(bus.count_state), 1);
    bus.halt_req = 1'b1;
    for (int p = 2; p <= 4; p++) begin
      @(negedge clk);
      chk("hr_cs", int'(bus.count_state), p);
      chk("hr_halted_mid", int'(bus.halted), 0);
      chk("hr_done", int'(bus.instr_done), int'(p == 4));
    end
    @(negedge clk);
    chk("hr_halted", int'(bus.halted), 1);
    chk("hr_cs0", int'(bus.count_state), 0);
    chk("hr_pv", int'(bus.phase_valid), 0);
    chk("hr_icount", int'(bus.instr_count), 9);
    @(negedge clk);
    chk("hr_stay", int'(bus.halted), 1);
    bus.halt_req = 1'b0;
    @(negedge clk);
    chk("hr_restart", int'(bus.halted), 0);
    chk("hr_restart_pv", int'(bus.phase_valid), 1);
    chk("hr_restart_cs", int'(bus.count_state), 0);

    // Reset mid-instruction at phase 3
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mr_pre_cs", int'(bus.count_state), 3);
    chk("mr_pre_icount", int'(bus.instr_count), 9);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_cs", int'(bus.count_state), 0);
    chk("mr_halted", int'(bus.halted), 1);
    chk("mr_icount", int'(bus.instr_count), 0);
    chk("mr_pv", int'(bus.phase_valid), 0);

    // Single-step, 4-phase instructions
    reset          = 1'b0;
    bus.run_mode   = 1'b0;
    bus.last_phase = 3'd3;
    @(negedge clk);
    chk("ss_idle", int'(bus.halted), 1);
    step_seq(24'h0FFFFF, pv);
    chk("ss_held_pv", pv, 4);
    chk("ss_held_halted", int'(bus.halted), 1);
    step_seq(24'h000005, pv);
    chk("ss_ignored_pv", pv, 4);
    step_seq(24'h000001, pv);
    chk("ss_pulse_pv", pv, 4);
    chk("ss_icount", int'(bus.instr_count), 3);

    // enable=0 in HALT blocks both step and free-run start
    bus.enable = 1'b0;
    step_seq(24'h000001, pv);
    chk("en0_step_pv", pv, 0);
    bus.run_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("en0_run_halted", int'(bus.halted), 1);
    chk("en0_icount", int'(bus.instr_count), 3);
    bus.run_mode = 1'b0;
    bus.enable   = 1'b1;

    // halt_req together with a step: step wins for exactly one instruction
    bus.halt_req = 1'b1;
    step_seq(24'h000001, pv);
    chk("hs_pv", pv, 4);
    chk("hs_halted", int'(bus.halted), 1);
    chk("hs_icount", int'(bus.instr_count), 4);
    bus.halt_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
